// File: rtl/iter_muldiv.sv
// Iterative unsigned multiplier (radix-2 shift-add) / divider (restoring), one operand bit per cycle.
// Fixed latency with a start/busy/done handshake; results hold until the next completion.
module iter_muldiv #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result_hi,
  output logic [WIDTH-1:0] result_lo,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nx;
  logic [CW-1:0]    cnt;
  logic             mode_q;
  logic [WIDTH-1:0] opnd;
  logic [WIDTH-1:0] acc_hi, acc_lo;
  logic [WIDTH:0]   mul_sum, div_sh, div_diff;
  logic [WIDTH-1:0] hi_nx, lo_nx;
  logic             last_iter;
  logic             start_dbz;

  assign last_iter = (cnt == CW'(1));
  assign start_dbz = mode && (b == '0);

  // opnd holds the multiplicand (multiply) or divisor (divide); acc_lo starts as multiplier or dividend
  always_comb begin
    mul_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
    div_sh   = {acc_hi, acc_lo[WIDTH-1]};
    div_diff = div_sh - {1'b0, opnd};
    if (mode_q) begin
      hi_nx = div_diff[WIDTH] ? div_sh[WIDTH-1:0] : div_diff[WIDTH-1:0];
      lo_nx = {acc_lo[WIDTH-2:0], ~div_diff[WIDTH]};
    end else begin
      hi_nx = mul_sum[WIDTH:1];
      lo_nx = {mul_sum[0], acc_lo[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    busy     = 1'b1;
    done     = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_nx = start_dbz ? DONE : RUN;
      end
      RUN:  if (last_iter) state_nx = DONE;
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt         <= '0;
      mode_q      <= 1'b0;
      opnd        <= '0;
      acc_hi      <= '0;
      acc_lo      <= '0;
      result_hi   <= '0;
      result_lo   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            mode_q <= mode;
            cnt    <= CW'(WIDTH);
            acc_hi <= '0;
            opnd   <= mode ? b : a;
            acc_lo <= mode ? a : b;
            if (start_dbz) begin
              cnt         <= '0;
              result_hi   <= a;
              result_lo   <= '1;
              div_by_zero <= 1'b1;
            end
          end
        end
        RUN: begin
          acc_hi <= hi_nx;
          acc_lo <= lo_nx;
          cnt    <= cnt - CW'(1);
          // results are published on the edge that enters DONE
          if (last_iter) begin
            result_hi   <= hi_nx;
            result_lo   <= lo_nx;
            div_by_zero <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_iter_muldiv.sv
// Scoreboard bench for iter_muldiv at WIDTH=8 (directed) and WIDTH=16 (model-checked random).
module tb_iter_muldiv;

  typedef struct {
    logic [15:0] hi;
    logic [15:0] lo;
    logic        dbz;
    int          lat;
    int          scyc;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_cmp = 0;
  int n_bad = 0;

  exp_t q8[$];
  exp_t q16[$];

  logic        rst8 = 1'b1, start8 = 1'b0, mode8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        busy8, done8, dbz8;
  logic [7:0]  hi8, lo8;

  logic        rst16 = 1'b1, start16 = 1'b0, mode16 = 1'b0;
  logic [15:0] a16 = '0, b16 = '0;
  logic        busy16, done16, dbz16;
  logic [15:0] hi16, lo16;

  iter_muldiv #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(rst8), .start(start8), .mode(mode8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .result_hi(hi8), .result_lo(lo8), .div_by_zero(dbz8));

  iter_muldiv #(.WIDTH(16)) dut16 (
    .clk(clk), .reset(rst16), .start(start16), .mode(mode16), .a(a16), .b(b16),
    .busy(busy16), .done(done16), .result_hi(hi16), .result_lo(lo16), .div_by_zero(dbz16));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // monitors: pop on done, otherwise require outputs to hold the last published values
  logic [15:0] held_hi8 = '0, held_lo8 = '0, held_hi16 = '0, held_lo16 = '0;
  logic        held_dbz8 = 1'b0, held_dbz16 = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    if (rst8) begin
      held_hi8 = '0; held_lo8 = '0; held_dbz8 = 1'b0;
    end else if (done8) begin
      if (q8.size() == 0) chk("w8_unexpected_done", 32'd1, 32'd0);
      else begin
        e = q8.pop_front();
        chk("w8_hi", {24'd0, hi8}, {16'd0, e.hi});
        chk("w8_lo", {24'd0, lo8}, {16'd0, e.lo});
        chk("w8_dbz", {31'd0, dbz8}, {31'd0, e.dbz});
        chk("w8_latency", cyc - e.scyc, e.lat);
        chk("w8_busy_in_done", {31'd0, busy8}, 32'd1);
      end
      held_hi8 = {8'd0, hi8}; held_lo8 = {8'd0, lo8}; held_dbz8 = dbz8;
    end else begin
      chk("w8_hold", {15'd0, dbz8, hi8, lo8}, {15'd0, held_dbz8, held_hi8[7:0], held_lo8[7:0]});
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst16) begin
      held_hi16 = '0; held_lo16 = '0; held_dbz16 = 1'b0;
    end else if (done16) begin
      if (q16.size() == 0) chk("w16_unexpected_done", 32'd1, 32'd0);
      else begin
        e = q16.pop_front();
        chk("w16_result", {hi16, lo16}, {e.hi, e.lo});
        chk("w16_dbz", {31'd0, dbz16}, {31'd0, e.dbz});
        chk("w16_latency", cyc - e.scyc, e.lat);
      end
      held_hi16 = hi16; held_lo16 = lo16; held_dbz16 = dbz16;
    end else begin
      chk("w16_hold", {hi16, lo16}, {held_hi16, held_lo16});
      chk("w16_hold_dbz", {31'd0, dbz16}, {31'd0, held_dbz16});
    end
  end

  task automatic wait_idle8();
    int k;
    k = 0;
    @(negedge clk);
    while (busy8 && k < 100) begin @(negedge clk); k++; end
    if (k >= 100) chk("w8_idle_timeout", 32'd1, 32'd0);
  endtask

  task automatic wait_idle16();
    int k;
    k = 0;
    @(negedge clk);
    while (busy16 && k < 100) begin @(negedge clk); k++; end
    if (k >= 100) chk("w16_idle_timeout", 32'd1, 32'd0);
  endtask

  task automatic op8(input logic m, input logic [7:0] ta, input logic [7:0] tb_v,
                     input logic [7:0] ehi, input logic [7:0] elo, input logic edbz);
    exp_t e;
    wait_idle8();
    start8 = 1'b1; mode8 = m; a8 = ta; b8 = tb_v;
    e.hi = {8'd0, ehi}; e.lo = {8'd0, elo}; e.dbz = edbz;
    e.lat = edbz ? 1 : 9; e.scyc = cyc;
    q8.push_back(e);
    @(posedge clk); #1;
    start8 = 1'b0; a8 = 8'hA5; b8 = 8'h3C; mode8 = ~m;
  endtask

  task automatic op16(input logic m, input logic [15:0] ta, input logic [15:0] tb_v);
    exp_t e;
    logic [31:0] p;
    wait_idle16();
    start16 = 1'b1; mode16 = m; a16 = ta; b16 = tb_v;
    if (!m) begin
      p = {16'd0, ta} * {16'd0, tb_v};
      e.hi = p[31:16]; e.lo = p[15:0]; e.dbz = 1'b0; e.lat = 17;
    end else if (tb_v == 16'd0) begin
      e.hi = ta; e.lo = 16'hFFFF; e.dbz = 1'b1; e.lat = 1;
    end else begin
      e.hi = ta % tb_v; e.lo = ta / tb_v; e.dbz = 1'b0; e.lat = 17;
    end
    e.scyc = cyc;
    q16.push_back(e);
    @(posedge clk); #1;
    start16 = 1'b0; a16 = 16'(~ta); b16 = 16'($urandom);
  endtask

  initial begin
    exp_t e;
    int   k;
    repeat (2) @(negedge clk);
    chk("rst_busy", {31'd0, busy8}, 32'd0);
    chk("rst_done", {31'd0, done8}, 32'd0);
    chk("rst_results", {15'd0, dbz8, hi8, lo8}, 32'd0);
    rst8 = 1'b0; rst16 = 1'b0;

    op8(1'b0, 8'd13,  8'd11,  8'h00, 8'h8F, 1'b0);
    op8(1'b0, 8'd255, 8'd255, 8'hFE, 8'h01, 1'b0);
    op8(1'b0, 8'd0,   8'd200, 8'h00, 8'h00, 1'b0);
    op8(1'b1, 8'd200, 8'd7,   8'd4,  8'd28, 1'b0);
    op8(1'b1, 8'd5,   8'd9,   8'd5,  8'd0,  1'b0);
    op8(1'b1, 8'h55,  8'd0,   8'h55, 8'hFF, 1'b1);
    op8(1'b1, 8'd100, 8'd10,  8'd0,  8'd10, 1'b0);
    op8(1'b1, 8'd255, 8'd1,   8'd0,  8'd255, 1'b0);
    op8(1'b0, 8'd128, 8'd2,   8'h01, 8'h00, 1'b0);

    // start held high: back-to-back operations every 10 cycles, mid-RUN start ignored
    wait_idle8();
    start8 = 1'b1; mode8 = 1'b0; a8 = 8'd13; b8 = 8'd11;
    for (int i = 0; i < 3; i++) begin
      e.hi = 16'h0000; e.lo = 16'h008F; e.dbz = 1'b0; e.lat = 9; e.scyc = cyc + 10 * i;
      q8.push_back(e);
    end
    repeat (25) @(posedge clk);
    @(negedge clk); start8 = 1'b0;

    // reset at RUN cycle 4 after a divide-by-zero left dbz and results set
    op8(1'b1, 8'h77, 8'd0, 8'h77, 8'hFF, 1'b1);
    op8(1'b0, 8'd9, 8'd7, 8'h00, 8'd63, 1'b0);
    void'(q8.pop_back());
    repeat (4) @(posedge clk);
    #2 rst8 = 1'b1;
    #1;
    chk("midrun_rst_busy", {31'd0, busy8}, 32'd0);
    chk("midrun_rst_done", {31'd0, done8}, 32'd0);
    chk("midrun_rst_results", {15'd0, dbz8, hi8, lo8}, 32'd0);
    repeat (2) @(negedge clk);
    rst8 = 1'b0;
    repeat (12) @(negedge clk);
    chk("midrun_rst_idle", {31'd0, busy8}, 32'd0);

    // reset and start in the same cycle: start is lost
    @(negedge clk); rst8 = 1'b1; start8 = 1'b1; mode8 = 1'b0; a8 = 8'd3; b8 = 8'd3;
    @(negedge clk); start8 = 1'b0; rst8 = 1'b0;
    @(negedge clk);
    chk("rst_start_busy", {31'd0, busy8}, 32'd0);

    op8(1'b0, 8'd16, 8'd16, 8'h01, 8'h00, 1'b0);

    op16(1'b0, 16'hFFFF, 16'hFFFF);
    op16(1'b1, 16'd1000, 16'd0);
    op16(1'b1, 16'd60000, 16'd7);
    for (int i = 0; i < 300; i++) begin
      logic [15:0] rb;
      rb = (i % 4 == 0) ? 16'($urandom_range(0, 20)) : 16'($urandom);
      op16(1'($urandom), 16'($urandom), rb);
    end

    k = 0;
    while ((q8.size() != 0 || q16.size() != 0) && k < 200) begin @(negedge clk); k++; end
    chk("drain_q8", q8.size(), 32'd0);
    chk("drain_q16", q16.size(), 32'd0);
    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
